// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux4 select-line scan sequencer.
// Contents: scan FSM state enum, channel count/width, settle counter width.
// Imported by next_ch_sel and mux_scan_ctrl.
package mux_scan_pkg;

    localparam int NUM_CH     = 4;
    localparam int CH_W       = 2;
    // Largest legal settle time; the counter is sized to hold SETTLE_MAX-1.
    localparam int SETTLE_MAX = 255;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/next_ch_sel.sv
// Purpose: combinational priority finder for the next enabled mux channel.
// Ports:   mask_i (channel enables), cur_ch_i (current channel), first_i (search
//          from channel 0 inclusive) -> next_ch_o (lowest hit), found_o (any hit).
module next_ch_sel
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_ch_i,
    input  logic              first_i,
    output logic [CH_W-1:0]   next_ch_o,
    output logic              found_o
);

    // Walk from the top channel down so the lowest qualifying channel is
    // the last assignment and therefore wins.
    always_comb begin
        next_ch_o = '0;
        found_o   = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_ch_i)))) begin
                next_ch_o = CH_W'(i);
                found_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Purpose: steps mux4 select lines over enabled channels, settling then sampling
//          each, and assembles a 4-bit snapshot of the mux inputs.
// Ports:   clk/rst_n (sync active-low), start/mask request, mux_out from mux4;
//          s0/s1 selects, busy, done pulse, result snapshot (all registered state).
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] mask,
    input  logic              mux_out,
    output logic              s0,
    output logic              s1,
    output logic              busy,
    output logic              done,
    output logic [NUM_CH-1:0] result
);

    // The SETTLE state runs from SETTLE_CYCLES-1 down to 0 inclusive.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t       state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] result_q, result_d;

    logic              in_idle;
    logic [NUM_CH-1:0] find_mask;
    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_found;

    // One finder serves both the first-channel lookup at accept (using the
    // live mask input, which is being latched that same edge) and each
    // advance after a sample (using the latched mask).
    assign in_idle   = (state_q == IDLE);
    assign find_mask = in_idle ? mask : mask_q;

    next_ch_sel u_next_ch_sel (
        .mask_i    (find_mask),
        .cur_ch_i  (sel_q),
        .first_i   (in_idle),
        .next_ch_o (nxt_ch),
        .found_o   (nxt_found)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d   = mask;
                    result_d = '0;
                    if (nxt_found) begin
                        sel_d   = nxt_ch;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        // Empty mask: select lines keep their old value.
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAMPLE: begin
                result_d[sel_q] = mux_out;
                if (nxt_found) begin
                    sel_d   = nxt_ch;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign s0     = sel_q[0];
    assign s1     = sel_q[1];
    assign busy   = !in_idle;
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start1;
    logic [3:0] mask, mask1;
    logic [3:0] c, c1;
    logic       glitch;

    logic       mux_out, s0, s1, busy, done;
    logic [3:0] result;
    logic       mux_out1, s0_1, s1_1, busy1, done1;
    logic [3:0] result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural mux4 in front of each sequencer.
    assign mux_out  = c[{s1, s0}];
    assign mux_out1 = c1[{s1_1, s0_1}] ^ glitch;

    mux_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .mux_out(mux_out),
        .s0(s0), .s1(s1), .busy(busy), .done(done), .result(result)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mask(mask1), .mux_out(mux_out1),
        .s0(s0_1), .s1(s1_1), .busy(busy1), .done(done1), .result(result1)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        mask   = 4'h0;
        mask1  = 4'h0;
        c      = 4'h0;
        c1     = 4'h0;
        glitch = 1'b0;
        tick;
        tick;

        // Reset values
        check4("rst_sel", {2'b00, s1, s0}, 4'b0000);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check4("rst_result", result, 4'b0000);
        check4("rst_sel1", {2'b00, s1_1, s0_1}, 4'b0000);
        check1("rst_busy1", busy1, 1'b0);
        rst_n = 1'b1;
        tick;

        // Full mask, c = 1,0,1,0: each select held 3 cycles, done at T+13
        c     = 4'b0101;
        mask  = 4'b1111;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k <= 12) check4("t1_sel", {2'b00, s1, s0}, 4'((k - 1) / 3));
            check1("t1_busy", busy, 1'b1);
            check1("t1_done", done, k == 13);
            if (k == 13) check4("t1_result", result, 4'b0101);
            tick;
        end
        check1("t1_busy_after", busy, 1'b0);
        check1("t1_done_after", done, 1'b0);
        check4("t1_result_hold", result, 4'b0101);
        check4("t1_sel_hold", {2'b00, s1, s0}, 4'b0011);

        // Sparse mask 1010, c = 0,1,1,1: only selects 01 and 11, done at T+7
        c     = 4'b1110;
        mask  = 4'b1010;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            if (k <= 6) check4("t2_sel", {2'b00, s1, s0}, (k <= 3) ? 4'd1 : 4'd3);
            check1("t2_busy", busy, 1'b1);
            check1("t2_done", done, k == 7);
            if (k == 7) check4("t2_result", result, 4'b1010);
            tick;
        end
        check1("t2_busy_after", busy, 1'b0);

        // Empty mask: done at T+1, result cleared, select unchanged
        mask  = 4'b0000;
        start = 1'b1;
        tick;
        check1("t3_done", done, 1'b1);
        check1("t3_busy", busy, 1'b1);
        check4("t3_result", result, 4'b0000);
        check4("t3_sel", {2'b00, s1, s0}, 4'b0011);
        // Start held through the DONE cycle is ignored there
        mask = 4'b1111;
        c    = 4'b0011;
        tick;
        check1("t3_start_in_done_busy", busy, 1'b0);
        check1("t3_start_in_done_done", done, 1'b0);

        // Start still high: accepted in this IDLE cycle. Mid-scan start and
        // mask change must not disturb the scan.
        tick;
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 3) begin
                start = 1'b1;
                mask  = 4'b0000;
            end
            if (k == 4) start = 1'b0;
            if (k <= 12) check4("t4_sel", {2'b00, s1, s0}, 4'((k - 1) / 3));
            check1("t4_busy", busy, 1'b1);
            check1("t4_done", done, k == 13);
            if (k == 13) check4("t4_result", result, 4'b0011);
            tick;
        end
        check1("t4_not_queued", busy, 1'b0);
        tick;
        check1("t4_not_queued2", busy, 1'b0);

        // Reset during SETTLE of channel 2
        c     = 4'b0101;
        mask  = 4'b1111;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) tick;
        check4("t5_sel_pre", {2'b00, s1, s0}, 4'b0010);
        check4("t5_result_pre", result, 4'b0001);
        check1("t5_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        tick;
        check4("t5_sel_rst", {2'b00, s1, s0}, 4'b0000);
        check1("t5_busy_rst", busy, 1'b0);
        check1("t5_done_rst", done, 1'b0);
        check4("t5_result_rst", result, 4'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick;
            check1("t5_no_done", done, 1'b0);
            check1("t5_idle", busy, 1'b0);
        end
        c     = 4'b1001;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k <= 12) check4("t5_sel", {2'b00, s1, s0}, 4'((k - 1) / 3));
            check1("t5_done", done, k == 13);
            if (k == 13) check4("t5_result", result, 4'b1001);
            tick;
        end

        // SETTLE_CYCLES=1: mux output wrong during first cycle of each select
        c1     = 4'b0110;
        mask1  = 4'b1111;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            glitch = (k <= 8) && (k % 2 == 1);
            if (k <= 8) check4("t6_sel", {2'b00, s1_1, s0_1}, 4'((k - 1) / 2));
            check1("t6_busy", busy1, 1'b1);
            check1("t6_done", done1, k == 9);
            if (k == 9) check4("t6_result", result1, 4'b0110);
            tick;
        end
        glitch = 1'b0;
        check1("t6_busy_after", busy1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
